// File: rtl/iq_pulse_capture_if.sv
// Bundle of the sample-capture handshake signals.
//   START, PULSE_LEN           : window arm pulse and sample count
//   IDATA, QDATA, VALID        : DDC sample stream (no backpressure)
//   DATA_OUT, ADDR_OUT,
//   OUT_VALID, OUT_READY       : packed {Q,I} output stream with sample index
//   BUSY, RECEIVE_OVER,
//   OVERFLOW                   : window status
// master drives the stimulus side, slave is the capture block.
interface iq_pulse_capture_if #(
    parameter int LEN_W = 16
);
    logic             START;
    logic [LEN_W-1:0] PULSE_LEN;
    logic [15:0]      IDATA;
    logic [15:0]      QDATA;
    logic             VALID;
    logic [31:0]      DATA_OUT;
    logic [LEN_W-1:0] ADDR_OUT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             BUSY;
    logic             RECEIVE_OVER;
    logic             OVERFLOW;

    modport master (
        output START, PULSE_LEN, IDATA, QDATA, VALID, OUT_READY,
        input  DATA_OUT, ADDR_OUT, OUT_VALID, BUSY, RECEIVE_OVER, OVERFLOW
    );

    modport slave (
        input  START, PULSE_LEN, IDATA, QDATA, VALID, OUT_READY,
        output DATA_OUT, ADDR_OUT, OUT_VALID, BUSY, RECEIVE_OVER, OVERFLOW
    );
endinterface

// File: rtl/iq_pulse_capture.sv
// Captures PULSE_LEN DDC samples per armed window, packs them as {Q,I},
// buffers them in a DEPTH-entry FIFO and drains them through a registered
// valid/ready port with a running sample address.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave view of iq_pulse_capture_if (see interface header)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for START
// S_CAPTURE | counting VALID strobes until len samples have arrived
// S_DRAIN   | capture finished, emptying FIFO and output register
// S_DONE    | one cycle; raises RECEIVE_OVER, drops BUSY
module iq_pulse_capture #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int LEN_W = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    iq_pulse_capture_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cap_cnt;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic [31:0]      data_out;
    logic [LEN_W-1:0] addr_out;
    logic             out_valid;
    logic             busy;
    logic             receive_over;
    logic             overflow;

    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_en;
    logic             rd_en;
    logic             drop;
    logic             out_xfer;

    logic             arm;
    logic             cap_en;
    logic             done;

    assign fifo_full  = (occ == OCC_FULL);
    assign fifo_empty = (occ == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.START) begin
                    state_nxt = (bus.PULSE_LEN == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // cap_cnt < len_q here, so the increment cannot wrap
                if (bus.VALID && ((cap_cnt + LEN_W'(1)) == len_q)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // a sample being accepted this cycle no longer counts as held
                if (fifo_empty && (!out_valid || bus.OUT_READY)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        arm    = 1'b0;
        cap_en = 1'b0;
        done   = 1'b0;
        case (state)
            S_IDLE:    arm    = bus.START;
            S_CAPTURE: cap_en = bus.VALID;
            S_DONE:    done   = 1'b1;
            default: ;
        endcase
    end

    assign wr_en    = cap_en && !fifo_full;
    assign drop     = cap_en && fifo_full;
    assign out_xfer = out_valid && bus.OUT_READY;
    assign rd_en    = !fifo_empty && (!out_valid || bus.OUT_READY);

    // ---------------- window control ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            len_q        <= '0;
            cap_cnt      <= '0;
            busy         <= 1'b0;
            receive_over <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            receive_over <= done;
            if (arm) begin
                len_q    <= bus.PULSE_LEN;
                cap_cnt  <= '0;
                busy     <= 1'b1;
                overflow <= 1'b0;
            end else begin
                if (cap_en) begin
                    cap_cnt <= cap_cnt + LEN_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.QDATA, bus.IDATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            addr_out  <= '0;
        end else begin
            if (rd_en) begin
                data_out  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
            // output path is always empty in IDLE, so START never races a transfer
            if (arm) begin
                addr_out <= '0;
            end else if (out_xfer) begin
                addr_out <= addr_out + LEN_W'(1);
            end
        end
    end

    assign bus.DATA_OUT     = data_out;
    assign bus.ADDR_OUT     = addr_out;
    assign bus.OUT_VALID    = out_valid;
    assign bus.BUSY         = busy;
    assign bus.RECEIVE_OVER = receive_over;
    assign bus.OVERFLOW     = overflow;

endmodule

// File: tb/tb_iq_pulse_capture.sv
module tb_iq_pulse_capture;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LEN_W = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    iq_pulse_capture_if #(.LEN_W(LEN_W)) bus ();

    iq_pulse_capture #(.DEPTH(DEPTH), .AW(AW), .LEN_W(LEN_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [LEN_W-1:0] addr;
        logic [31:0]      data;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   ro_count   = 0;
    int   delivered  = 0;
    int   ready_mode = 0;   // 0 always 1, 1 random, 2 toggle, 3 held low

    logic             stall_prev = 1'b0;
    logic [31:0]      d_prev     = '0;
    logic [LEN_W-1:0] a_prev     = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // downstream ready generator
    initial begin
        bus.OUT_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       bus.OUT_READY = 1'b1;
                1:       bus.OUT_READY = 1'($urandom_range(0, 1));
                2:       bus.OUT_READY = ~bus.OUT_READY;
                default: bus.OUT_READY = 1'b0;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (stall_prev) begin
                    chk("stall_valid", 64'(bus.OUT_VALID), 64'd1);
                    chk("stall_data", 64'(bus.DATA_OUT), 64'(d_prev));
                    chk("stall_addr", 64'(bus.ADDR_OUT), 64'(a_prev));
                end
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out got data %0h addr %0d want no transfer",
                                 bus.DATA_OUT, bus.ADDR_OUT);
                    end else begin
                        e = exp_q.pop_front();
                        delivered++;
                        chk("out_data", 64'(bus.DATA_OUT), 64'(e.data));
                        chk("out_addr", 64'(bus.ADDR_OUT), 64'(e.addr));
                    end
                end
                if (bus.RECEIVE_OVER) begin
                    ro_count++;
                    chk("ro_all_delivered", 64'(exp_q.size()), 64'd0);
                end
                stall_prev = bus.OUT_VALID && !bus.OUT_READY;
                d_prev     = bus.DATA_OUT;
                a_prev     = bus.ADDR_OUT;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic start_window(input int len);
        bus.START     = 1'b1;
        bus.PULSE_LEN = LEN_W'(len);
        tick();
        bus.START     = 1'b0;
        bus.PULSE_LEN = LEN_W'($urandom);
    endtask

    // gap=0: VALID random; gap=k: VALID every k-th cycle.
    // Only the first 'keep' strobed samples are expected downstream.
    task automatic feed(input int n, input int keep, input int gap, input int glitch_at);
        int sent = 0;
        int cyc  = 0;
        while (sent < n) begin
            logic v;
            v = (gap == 0) ? 1'($urandom_range(0, 1)) : ((cyc % gap) == 0);
            bus.VALID     = v;
            bus.IDATA     = 16'($urandom);
            bus.QDATA     = 16'($urandom);
            bus.START     = (cyc == glitch_at);
            bus.PULSE_LEN = LEN_W'(3);
            if (v) begin
                if (sent < keep) begin
                    exp_q.push_back('{addr: LEN_W'(sent), data: {bus.QDATA, bus.IDATA}});
                end
                sent++;
            end
            tick();
            cyc++;
        end
        bus.VALID = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic wait_ro(input string name, input int exp_deliv, input int d0, input logic exp_ovf);
        int r0 = ro_count;
        int n  = 0;
        while (ro_count == r0 && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_ro_count"}, 64'(ro_count - r0), 64'd1);
        chk({name, "_ro_single"}, 64'(bus.RECEIVE_OVER), 64'd0);
        chk({name, "_busy_low"}, 64'(bus.BUSY), 64'd0);
        chk({name, "_delivered"}, 64'(delivered - d0), 64'(exp_deliv));
        chk({name, "_overflow"}, 64'(bus.OVERFLOW), 64'(exp_ovf));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_out_valid"}, 64'(bus.OUT_VALID), 64'd0);
        chk({name, "_data"}, 64'(bus.DATA_OUT), 64'd0);
        chk({name, "_addr"}, 64'(bus.ADDR_OUT), 64'd0);
        chk({name, "_busy"}, 64'(bus.BUSY), 64'd0);
        chk({name, "_ro"}, 64'(bus.RECEIVE_OVER), 64'd0);
        chk({name, "_ovf"}, 64'(bus.OVERFLOW), 64'd0);
    endtask

    initial begin
        int d0;
        int r0;
        int len;
        logic [31:0] s0;
        bus.START     = 1'b0;
        bus.PULSE_LEN = '0;
        bus.IDATA     = '0;
        bus.QDATA     = '0;
        bus.VALID     = 1'b0;

        // reset with stream activity
        RESET = 1'b1;
        repeat (4) begin
            bus.VALID = 1'($urandom_range(0, 1));
            bus.IDATA = 16'($urandom);
            bus.QDATA = 16'($urandom);
            tick();
        end
        check_all_zero("reset");
        RESET     = 1'b0;
        bus.VALID = 1'b0;
        tick();

        // len=8 back to back with ready high, plus first-output latency
        d0 = delivered;
        start_window(8);
        chk("t1_busy", 64'(bus.BUSY), 64'd1);
        s0 = '0;
        for (int i = 0; i < 8; i++) begin
            bus.VALID = 1'b1;
            bus.IDATA = 16'($urandom);
            bus.QDATA = 16'($urandom);
            if (i == 0) s0 = {bus.QDATA, bus.IDATA};
            exp_q.push_back('{addr: LEN_W'(i), data: {bus.QDATA, bus.IDATA}});
            tick();
            if (i == 0) chk("t1_lat_edge_t", 64'(bus.OUT_VALID), 64'd0);
            if (i == 1) begin
                chk("t1_lat_edge_t1", 64'(bus.OUT_VALID), 64'd1);
                chk("t1_first_data", 64'(bus.DATA_OUT), 64'(s0));
            end
        end
        bus.VALID = 1'b0;
        wait_ro("t1", 8, d0, 1'b0);

        // VALID while idle must not produce output
        repeat (5) begin
            bus.VALID = 1'b1;
            bus.IDATA = 16'($urandom);
            tick();
        end
        bus.VALID = 1'b0;
        repeat (3) tick();
        chk("idle_valid_ignored", 64'(bus.OUT_VALID), 64'd0);

        // len=0: DONE right after START, START in DONE ignored
        r0 = ro_count;
        start_window(0);
        chk("t2_busy_1", 64'(bus.BUSY), 64'd1);
        chk("t2_ro_0", 64'(bus.RECEIVE_OVER), 64'd0);
        bus.START     = 1'b1;
        bus.PULSE_LEN = LEN_W'(5);
        tick();
        bus.START = 1'b0;
        chk("t2_ro_1", 64'(bus.RECEIVE_OVER), 64'd1);
        chk("t2_busy_0", 64'(bus.BUSY), 64'd0);
        tick();
        chk("t2_ro_pulse_end", 64'(bus.RECEIVE_OVER), 64'd0);
        chk("t2_start_in_done_ignored", 64'(bus.BUSY), 64'd0);
        chk("t2_no_out", 64'(bus.OUT_VALID), 64'd0);
        chk("t2_ro_count", 64'(ro_count - r0), 64'd1);

        // overflow: len=100 with ready held low during capture
        ready_mode = 3;
        tick();
        tick();
        d0 = delivered;
        start_window(100);
        feed(100, DEPTH + 1, 1, -1);
        chk("t3_ovf_during_drain", 64'(bus.OVERFLOW), 64'd1);
        ready_mode = 0;
        wait_ro("t3", DEPTH + 1, d0, 1'b1);

        // len=16, VALID every 3rd cycle, ready toggling
        ready_mode = 2;
        d0 = delivered;
        start_window(16);
        chk("t4_ovf_cleared", 64'(bus.OVERFLOW), 64'd0);
        feed(16, 16, 3, -1);
        wait_ro("t4", 16, d0, 1'b0);

        // START during capture ignored; next START restarts the address
        ready_mode = 1;
        d0 = delivered;
        start_window(12);
        feed(12, 12, 0, 4);
        wait_ro("t5a", 12, d0, 1'b0);
        d0 = delivered;
        start_window(5);
        feed(5, 5, 0, -1);
        wait_ro("t5b", 5, d0, 1'b0);

        // reset during drain with samples buffered
        ready_mode = 3;
        tick();
        tick();
        start_window(6);
        feed(6, 6, 1, -1);
        tick();
        chk("t6_holding", 64'(bus.OUT_VALID), 64'd1);
        chk("t6_busy", 64'(bus.BUSY), 64'd1);
        r0    = ro_count;
        RESET = 1'b1;
        tick();
        check_all_zero("t6_rst");
        exp_q.delete();
        RESET      = 1'b0;
        ready_mode = 0;
        repeat (6) tick();
        chk("t6_no_ro", 64'(ro_count - r0), 64'd0);
        chk("t6_fifo_empty", 64'(bus.OUT_VALID), 64'd0);
        d0 = delivered;
        start_window(10);
        feed(10, 10, 0, -1);
        wait_ro("t6_after", 10, d0, 1'b0);

        // random windows
        ready_mode = 1;
        for (int w = 0; w < 6; w++) begin
            len = $urandom_range(1, 60);
            d0  = delivered;
            start_window(len);
            feed(len, len, 0, -1);
            wait_ro("rand", len, d0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iq_pulse_capture.md
Name: iq_pulse_capture

Overview:
- Sits directly downstream of the DDC in the receiver chain.
- Consumes the DDC's I/Q sample stream and captures exactly PULSE_LEN samples per armed pulse window.
- Packs each sample as {Q,I}, buffers it in an internal FIFO, and drains it through a valid/ready port with a running sample address.
- Raises RECEIVE_OVER once the whole window has been delivered downstream.

Parameters:
- DEPTH, 64, internal FIFO entries; power of two, minimum 4.
- AW, 6, log2(DEPTH); FIFO pointer width.
- LEN_W, 16, width of PULSE_LEN and ADDR_OUT.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle arm pulse; latches PULSE_LEN.
- PULSE_LEN  in  LEN_W  number of samples to capture in this window.
- IDATA  in  16  DDC in-phase sample.
- QDATA  in  16  DDC quadrature sample.
- VALID  in  1  DDC sample strobe; no backpressure toward the DDC.
- DATA_OUT  out  32  {QDATA,IDATA} of the current output sample.
- ADDR_OUT  out  LEN_W  index of the sample in DATA_OUT, 0 .. len-1.
- OUT_VALID  out  1  DATA_OUT/ADDR_OUT are valid.
- OUT_READY  in  1  downstream accepts the sample.
- BUSY  out  1  high from START acceptance until RECEIVE_OVER.
- RECEIVE_OVER  out  1  one-cycle pulse at the end of the window.
- OVERFLOW  out  1  sticky flag: a sample was dropped because the FIFO was full.

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO emptied; internal counters 0. Reset wins over every other input in the same cycle, including mid-capture and mid-drain. An aborted window produces no RECEIVE_OVER.
- State IDLE:
  - START=1 latches len=PULSE_LEN, clears the capture counter, output address and OVERFLOW, and sets BUSY on the next edge.
  - If len=0, go to DONE; otherwise go to CAPTURE.
- State CAPTURE:
  - Each cycle with VALID=1 increments the capture counter.
  - If the FIFO is not full, {QDATA,IDATA} is written. If it is full, the sample is dropped, OVERFLOW is set, and the counter still increments.
  - When the counter reaches len, go to DRAIN. The sample arriving in that final cycle is still written (or dropped).
  - VALID outside CAPTURE is ignored.
- State DRAIN: when the FIFO is empty and the output register is not holding an unaccepted sample, go to DONE.
- State DONE:
  - RECEIVE_OVER=1 for exactly one cycle; BUSY drops on the same edge; return to IDLE.
  - START in the DONE cycle is ignored.
- START in CAPTURE or DRAIN is ignored; len and counters are unchanged.
- Output register:
  - Loads from the FIFO head when the FIFO is non-empty and (OUT_VALID=0 or OUT_READY=1).
  - OUT_VALID, DATA_OUT and ADDR_OUT stay stable while OUT_VALID=1 and OUT_READY=0.
  - ADDR_OUT increments by 1 on each accepted transfer (OUT_VALID & OUT_READY) and restarts at 0 on START.
  - With dropped samples, ADDR_OUT counts delivered samples, not captured indices.
- Latency:
  - A sample strobed at edge t is written to the FIFO at edge t.
  - With the output path free, it is loaded into the output register at edge t+1, and OUT_VALID is visible after edge t+1.
  - Full throughput: one sample per cycle with OUT_READY held high.
- FIFO:
  - Read and write in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - Full means occupancy = DEPTH; empty means occupancy = 0; an AW+1-bit occupancy counter is used.
- Counter arithmetic: capture counter is LEN_W bits. len = 2^LEN_W-1 is legal, and the counter never wraps within a window.

Test Plan:
- Reset mid-stream; START, len=8; 8 consecutive VALID with OUT_READY=1 -> ADDR_OUT 0..7, DATA_OUT = {Q,I} in order, first OUT_VALID 1 cycle after the first VALID, RECEIVE_OVER single pulse after the 8th transfer, OVERFLOW=0.
- len=0, START -> RECEIVE_OVER pulses 2 cycles after START, no OUT_VALID, BUSY high for exactly 1 cycle.
- DEPTH=64, len=100, VALID every cycle, OUT_READY=0 until capture ends -> OVERFLOW=1, exactly 65 samples delivered (64 FIFO + 1 output register), ADDR_OUT 0..64, then RECEIVE_OVER.
- len=16, VALID every 3rd cycle, OUT_READY toggling 1/0 -> DATA_OUT/ADDR_OUT stable during stalls, all 16 delivered in order, no OVERFLOW.
- Second START during CAPTURE with a different PULSE_LEN -> ignored; original len honoured; a subsequent START after RECEIVE_OVER restarts ADDR_OUT at 0.
- RESET asserted during DRAIN with 5 samples still buffered -> next cycle all outputs 0, no RECEIVE_OVER, FIFO empty; a new window then works normally.
